// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller.
// Issues one-at-a-time requests to the ICache under a credit limit and
// buffers returned instructions in a small FIFO for decode. Redirects flush
// the FIFO and drop any outstanding response.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   redirect_valid, redirect_pc  branch/exception redirect
//   ic_valid, ic_tag, ic_index,  ICache request (physical address fields)
//   ic_offset, ic_is_cache
//   ic_stall                     freezes the ICache request buffer
//   ic_busy, ic_rdata            ICache status and read data
//   inst_valid, inst_ready,      instruction queue head to decode
//   inst_pc, inst
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ic_valid,
    output logic [19:0] ic_tag,
    output logic [7:0]  ic_index,
    output logic [3:0]  ic_offset,
    output logic        ic_is_cache,
    output logic        ic_stall,
    input  logic        ic_busy,
    input  logic [31:0] ic_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        req_pc;
    logic               inflight;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        q_pc   [FQ_DEPTH];
    logic [31:0]        q_inst [FQ_DEPTH];

    logic [31:0]        paddr;
    logic               credit_ok;
    logic               accept;
    logic               resp;
    logic               push;
    logic               pop;

    // Address translation and request qualification
    always_comb begin
        paddr       = (pc[31:30] == 2'b10) ? {3'b000, pc[28:0]} : pc;
        ic_tag      = paddr[31:12];
        ic_index    = paddr[11:4];
        ic_offset   = paddr[3:0];
        ic_is_cache = (pc[31:29] != 3'b101);
        ic_stall    = ic_busy;
        credit_ok   = (count + CNT_W'(inflight)) < CNT_W'(FQ_DEPTH);
        ic_valid    = resetn && (state == RUN) && !redirect_valid && credit_ok;
        accept      = ic_valid && !ic_busy;
        resp        = inflight && !ic_busy;
        push        = resp && (state == RUN) && !redirect_valid;
        inst_valid  = resetn && (count != '0);
        pop         = inst_valid && inst_ready && !redirect_valid;
        inst_pc     = q_pc[rd_ptr];
        inst        = q_inst[rd_ptr];
    end

    // Fetch state, credit tracking and instruction queue
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= RUN;
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // A miss still in progress must be drained; a response arriving now is just dropped.
            if (inflight && ic_busy) begin
                state <= DRAIN;
            end else begin
                inflight <= 1'b0;
                state    <= RUN;
            end
        end else begin
            if (accept) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (state == DRAIN) begin
                if (!ic_busy) begin
                    inflight <= 1'b0;
                    state    <= RUN;
                end
            end else begin
                inflight <= accept || (inflight && ic_busy);
            end
            if (push) begin
                q_pc[wr_ptr]   <= req_pc;
                q_inst[wr_ptr] <= ic_rdata;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The credit limit must make a push into a full queue impossible
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(push && (count == CNT_W'(FQ_DEPTH))))
                else $error("if_fetch_ctrl: push into full instruction queue");
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios, a transaction-level
// model checked every cycle, and literal expectations at key points.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ic_valid;
    logic [19:0] ic_tag;
    logic [7:0]  ic_index;
    logic [3:0]  ic_offset;
    logic        ic_is_cache;
    logic        ic_stall;
    logic        ic_busy = 1'b0;
    logic [31:0] ic_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_pc;
    logic [31:0] inst;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    if_fetch_ctrl #(.RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ic_valid(ic_valid), .ic_tag(ic_tag), .ic_index(ic_index),
        .ic_offset(ic_offset), .ic_is_cache(ic_is_cache), .ic_stall(ic_stall),
        .ic_busy(ic_busy), .ic_rdata(ic_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst(inst)
    );

    always #5 clk = ~clk;

    // Fresh read data every cycle so each pushed entry is distinguishable
    always @(posedge clk) begin
        #1;
        cyc      = cyc + 1;
        ic_rdata = 32'hC0DE_0000 + 32'(cyc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: the fetch engine as "next pc, at most one outstanding request,
    // whether its answer is wanted, and a list of buffered instructions".
    logic [31:0] m_pc = RESET_PC;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_pc = '0;
    logic        m_drop = 1'b0;
    logic [63:0] fq[$];
    logic        e_valid, e_resp, e_pop;
    logic [31:0] e_phys;

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_ic_valid", 32'(ic_valid), 32'd0);
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            m_pc = RESET_PC; m_pend = 1'b0; m_drop = 1'b0; fq.delete();
        end else begin
            e_valid = !m_drop && !redirect_valid && (fq.size() + int'(m_pend)) < DEPTH;
            chk("ic_valid", 32'(ic_valid), 32'(e_valid));
            chk("ic_stall", 32'(ic_stall), 32'(ic_busy));
            if (e_valid) begin
                e_phys = (m_pc[31:30] == 2'b10) ? (m_pc & 32'h1FFF_FFFF) : m_pc;
                chk("ic_addr", {ic_tag, ic_index, ic_offset}, e_phys);
                chk("ic_is_cache", 32'(ic_is_cache), 32'(m_pc[31:29] != 3'b101));
            end
            chk("inst_valid", 32'(inst_valid), 32'(fq.size() != 0));
            if (fq.size() != 0) begin
                chk("inst_pc", inst_pc, fq[0][63:32]);
                chk("inst", inst, fq[0][31:0]);
            end
            e_resp = m_pend && !ic_busy;
            e_pop  = (fq.size() != 0) && inst_ready;
            if (redirect_valid) begin
                fq.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                if (m_pend && ic_busy) m_drop = 1'b1;
                else begin m_pend = 1'b0; m_drop = 1'b0; end
            end else begin
                if (e_pop) void'(fq.pop_front());
                if (e_resp) begin
                    if (!m_drop) fq.push_back({m_pend_pc, ic_rdata});
                    m_pend = 1'b0; m_drop = 1'b0;
                end
                if (e_valid && !ic_busy) begin
                    m_pend = 1'b1; m_pend_pc = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Apply inputs for the next cycle and hold them for n cycles
    task automatic drive(input logic rst_n, input logic rv, input logic [31:0] rp,
                         input logic busy, input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            resetn = rst_n; redirect_valid = rv; redirect_pc = rp;
            ic_busy = busy; inst_ready = rdy;
        end
    endtask

    task automatic mid;
        @(negedge clk); #1;
    endtask

    initial begin
        // Reset
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
        mid;
        chk("lit_rst_ic_valid", 32'(ic_valid), 32'd0);

        // Streaming from RESET_PC, one instruction per cycle
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_first_req_valid", 32'(ic_valid), 32'd1);
        chk("lit_first_req_addr", {ic_tag, ic_index, ic_offset}, 32'h1FC0_0000);
        chk("lit_first_req_uncached", 32'(ic_is_cache), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2);
        mid;
        chk("lit_c2_inst_valid", 32'(inst_valid), 32'd1);
        chk("lit_c2_inst_pc", inst_pc, 32'hBFC0_0000);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_c3_inst_pc", inst_pc, 32'hBFC0_0004);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3);

        // Decode stalls for 10 cycles: queue fills, credit runs out
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 10);
        mid;
        chk("lit_full_ic_valid", 32'(ic_valid), 32'd0);
        chk("lit_full_inst_valid", 32'(inst_valid), 32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 8);

        // Miss on 0x80001000 for 8 cycles
        drive(1'b1, 1'b1, 32'h8000_1000, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4);
        mid;
        chk("lit_miss_stall", 32'(ic_stall), 32'd1);
        chk("lit_miss_pc_frozen", {ic_tag, ic_index, ic_offset}, 32'h0000_1004);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_miss_inst_pc", inst_pc, 32'h8000_1000);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3);

        // Redirect during the 3rd busy cycle of a miss: drain then refetch
        drive(1'b1, 1'b1, 32'h8000_3000, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2);
        drive(1'b1, 1'b1, 32'h8000_2000, 1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        mid;
        chk("lit_drain_ic_valid", 32'(ic_valid), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_post_drain_addr", {ic_tag, ic_index, ic_offset}, 32'h0000_2000);
        chk("lit_post_drain_empty", 32'(inst_valid), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3);

        // Full queue, then redirect together with a pop
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8);
        drive(1'b1, 1'b1, 32'h0000_0102, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_redir_pop_empty", 32'(inst_valid), 32'd0);
        chk("lit_redir_kuseg_index", 32'(ic_index), 32'h10);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3);

        // PC wrap at the top of the address space
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_top_addr", {ic_tag, ic_index, ic_offset}, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_wrap_addr", {ic_tag, ic_index, ic_offset}, 32'h0000_0000);
        chk("lit_wrap_cached", 32'(ic_is_cache), 32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 3);

        // Reset in the middle of a miss
        drive(1'b1, 1'b1, 32'h8000_4000, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        mid;
        chk("lit_rst2_addr", {ic_tag, ic_index, ic_offset}, 32'h1FC0_0000);
        chk("lit_rst2_empty", 32'(inst_valid), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4);
        mid;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
